// File: rtl/inst_package.sv
// Instruction-set definitions shared by the writeback stage and its scoreboard.
package inst_package;

  // Opcode field of one 32-bit slot.
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int SLOT_W  = 32;

  typedef enum logic [5:0] {
    OP_NOP    = 6'd0,
    OP_LOAD   = 6'd1,
    OP_STORE  = 6'd2,
    OP_ADD    = 6'd3,
    OP_SUB    = 6'd4,
    OP_AND    = 6'd5,
    OP_OR     = 6'd6,
    OP_BRANCH = 6'd7,
    OP_ADDI   = 6'd8
  } opcode_t;

  // One scoreboard entry: an in-flight load destination.
  typedef struct packed {
    logic       vld;
    logic [4:0] rt;
  } sb_entry_t;

  // True for opcodes whose result lands in register rt.
  function automatic logic writes_rt(input opcode_t op);
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: writes_rt = 1'b1;
      default:                                         writes_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_load_scoreboard.sv
// Tracks in-flight loads per slot until their writeback has landed and
// flags decode when one of its source registers still waits on one.
module load_scoreboard
  import inst_package::*;
#(
  parameter int MEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interlock,
  input  logic        u_ld_issue,
  input  logic [4:0]  u_ld_rt,
  input  logic        l_ld_issue,
  input  logic [4:0]  l_ld_rt,
  input  logic [19:0] id_rs,
  output logic        load_hazard
);

  // One extra entry covers the cycle in which the register-file write lands.
  localparam int DEPTH = MEM_LATENCY + 1;

  sb_entry_t r_u_chain [DEPTH];
  sb_entry_t r_l_chain [DEPTH];
  logic      w_hazard;

  // Shift chains advance only on accepted edges; interlock freezes the countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_u_chain[i] <= '0;
        r_l_chain[i] <= '0;
      end
    end else if (!interlock) begin
      r_u_chain[0] <= '{vld: u_ld_issue && (u_ld_rt != 5'd0), rt: u_ld_rt};
      r_l_chain[0] <= '{vld: l_ld_issue && (l_ld_rt != 5'd0), rt: l_ld_rt};
      for (int i = 1; i < DEPTH; i++) begin
        r_u_chain[i] <= r_u_chain[i-1];
        r_l_chain[i] <= r_l_chain[i-1];
      end
    end
  end

  // Compare every nonzero decode source against issuing loads and live chain entries.
  always_comb begin
    w_hazard = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [4:0] rs;
      rs = id_rs[s*5 +: 5];
      if (rs != 5'd0) begin
        if (u_ld_issue && (u_ld_rt == rs)) w_hazard = 1'b1;
        if (l_ld_issue && (l_ld_rt == rs)) w_hazard = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (r_u_chain[i].vld && (r_u_chain[i].rt == rs)) w_hazard = 1'b1;
          if (r_l_chain[i].vld && (r_l_chain[i].rt == rs)) w_hazard = 1'b1;
        end
      end
    end
  end

  // Reset forces the stall off at once, even while an issue input is still high.
  assign load_hazard = w_hazard && !rst;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage for the dual-issue pipeline: selects write sources for
// both register-file ports, counts retired slots and hosts the load scoreboard.
module wb_stage
  import inst_package::*;
#(
  parameter int MEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interlock,
  input  logic [31:0] pc,
  input  logic [63:0] inst,
  input  logic [4:0]  u_rt,
  input  logic [4:0]  l_rt,
  input  logic [31:0] mem_douta,
  input  logic [31:0] mem_doutb,
  input  logic [31:0] u_alu,
  input  logic [31:0] l_alu,
  input  logic        u_ld_issue,
  input  logic        l_ld_issue,
  input  logic [4:0]  u_ld_rt,
  input  logic [4:0]  l_ld_rt,
  input  logic [19:0] id_rs,
  output logic        load_hazard,
  output logic        u_we,
  output logic        l_we,
  output logic [4:0]  u_waddr,
  output logic [4:0]  l_waddr,
  output logic [31:0] u_wdata,
  output logic [31:0] l_wdata,
  output logic [31:0] retired_pc,
  output logic [31:0] retire_count
);

  opcode_t     w_u_op;
  opcode_t     w_l_op;
  logic        w_u_wr;
  logic        w_l_wr;
  logic        w_u_we;
  logic [31:0] w_u_wdata;
  logic [31:0] w_l_wdata;
  logic [31:0] w_retire_inc;
  logic        w_unused;

  logic        r_u_we;
  logic        r_l_we;
  logic [4:0]  r_u_waddr;
  logic [4:0]  r_l_waddr;
  logic [31:0] r_u_wdata;
  logic [31:0] r_l_wdata;
  logic [31:0] r_retired_pc;
  logic [31:0] r_retire_count;

  assign w_u_op = opcode_t'(inst[SLOT_W+OPC_LSB +: OPC_W]);
  assign w_l_op = opcode_t'(inst[OPC_LSB +: OPC_W]);

  // Only the opcode fields matter here; the rest of the bundle was consumed upstream.
  assign w_unused = ^{inst[SLOT_W+OPC_LSB-1:SLOT_W], inst[OPC_LSB-1:0]};

  // Slot decode: write qualification, same-destination arbitration and source select.
  always_comb begin
    w_u_wr       = writes_rt(w_u_op) && (u_rt != 5'd0);
    w_l_wr       = writes_rt(w_l_op) && (l_rt != 5'd0);
    // The lower slot is younger, so it owns a shared destination.
    w_u_we       = w_u_wr && !(w_l_wr && (u_rt == l_rt));
    w_u_wdata    = (w_u_op == OP_LOAD) ? mem_douta : u_alu;
    w_l_wdata    = (w_l_op == OP_LOAD) ? mem_doutb : l_alu;
    w_retire_inc = 32'(w_u_op != OP_NOP) + 32'(w_l_op != OP_NOP);
  end

  // Write-port and retire registers; a stalled edge drops the enables but holds the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_u_we         <= 1'b0;
      r_l_we         <= 1'b0;
      r_u_waddr      <= '0;
      r_l_waddr      <= '0;
      r_u_wdata      <= '0;
      r_l_wdata      <= '0;
      r_retired_pc   <= '0;
      r_retire_count <= '0;
    end else if (interlock) begin
      r_u_we <= 1'b0;
      r_l_we <= 1'b0;
    end else begin
      r_u_we         <= w_u_we;
      r_l_we         <= w_l_wr;
      r_u_waddr      <= u_rt;
      r_l_waddr      <= l_rt;
      r_u_wdata      <= w_u_wdata;
      r_l_wdata      <= w_l_wdata;
      r_retired_pc   <= pc;
      r_retire_count <= r_retire_count + w_retire_inc;
    end
  end

  assign u_we         = r_u_we;
  assign l_we         = r_l_we;
  assign u_waddr      = r_u_waddr;
  assign l_waddr      = r_l_waddr;
  assign u_wdata      = r_u_wdata;
  assign l_wdata      = r_l_wdata;
  assign retired_pc   = r_retired_pc;
  assign retire_count = r_retire_count;

  load_scoreboard #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_load_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .interlock   (interlock),
    .u_ld_issue  (u_ld_issue),
    .u_ld_rt     (u_ld_rt),
    .l_ld_issue  (l_ld_issue),
    .l_ld_rt     (l_ld_rt),
    .id_rs       (id_rs),
    .load_hazard (load_hazard)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: writeback selection, arbitration, interlock,
// retire counting and load-scoreboard timing.
module tb_wb_stage;

  localparam logic [5:0] T_NOP  = 6'd0;
  localparam logic [5:0] T_LOAD = 6'd1;
  localparam logic [5:0] T_ADD  = 6'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        interlock;
  logic [31:0] pc;
  logic [63:0] inst;
  logic [4:0]  u_rt, l_rt;
  logic [31:0] mem_douta, mem_doutb, u_alu, l_alu;
  logic        u_ld_issue, l_ld_issue;
  logic [4:0]  u_ld_rt, l_ld_rt;
  logic [19:0] id_rs;
  logic        load_hazard, u_we, l_we;
  logic [4:0]  u_waddr, l_waddr;
  logic [31:0] u_wdata, l_wdata, retired_pc, retire_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  wb_stage #(.MEM_LATENCY(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .interlock    (interlock),
    .pc           (pc),
    .inst         (inst),
    .u_rt         (u_rt),
    .l_rt         (l_rt),
    .mem_douta    (mem_douta),
    .mem_doutb    (mem_doutb),
    .u_alu        (u_alu),
    .l_alu        (l_alu),
    .u_ld_issue   (u_ld_issue),
    .l_ld_issue   (l_ld_issue),
    .u_ld_rt      (u_ld_rt),
    .l_ld_rt      (l_ld_rt),
    .id_rs        (id_rs),
    .load_hazard  (load_hazard),
    .u_we         (u_we),
    .l_we         (l_we),
    .u_waddr      (u_waddr),
    .l_waddr      (l_waddr),
    .u_wdata      (u_wdata),
    .l_wdata      (l_wdata),
    .retired_pc   (retired_pc),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [5:0] uop, input logic [5:0] lop,
                            input logic [4:0] urt, input logic [4:0] lrt,
                            input logic [31:0] ua, input logic [31:0] la,
                            input logic [31:0] da, input logic [31:0] db,
                            input logic [31:0] p);
    inst      = {uop, 26'h0, lop, 26'h0};
    u_rt      = urt;
    l_rt      = lrt;
    u_alu     = ua;
    l_alu     = la;
    mem_douta = da;
    mem_doutb = db;
    pc        = p;
  endtask

  task automatic clear_inputs();
    interlock  = 1'b0;
    u_ld_issue = 1'b0;
    l_ld_issue = 1'b0;
    u_ld_rt    = 5'd0;
    l_ld_rt    = 5'd0;
    id_rs      = 20'd0;
    set_bundle(T_NOP, T_NOP, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    checks++;
    if ({u_we, l_we, u_waddr, l_waddr, u_wdata, l_wdata, retired_pc, retire_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b/%b count=%h pc=%h, expected all zero",
               u_we, l_we, retire_count, retired_pc);
    end
    checks++;
    if (load_hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_hazard: got %b expected 0", load_hazard);
    end
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_load_alu();
    set_bundle(T_LOAD, T_ADD, 5'd5, 5'd6, 32'h55, 32'h12, 32'hDEADBEEF, 32'h99, 32'h100);
    step();
    exp_cnt = exp_cnt + 32'd2;
    checks++;
    if ({u_we, u_waddr, u_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL load_upper: got we=%b addr=%0d data=%h expected 1/5/deadbeef", u_we, u_waddr, u_wdata);
    end
    checks++;
    if ({l_we, l_waddr, l_wdata} !== {1'b1, 5'd6, 32'h12}) begin
      errors++;
      $display("FAIL alu_lower: got we=%b addr=%0d data=%h expected 1/6/00000012", l_we, l_waddr, l_wdata);
    end
    checks++;
    if (retire_count !== exp_cnt || retired_pc !== 32'h100) begin
      errors++;
      $display("FAIL load_alu_retire: got count=%h pc=%h expected %h/00000100", retire_count, retired_pc, exp_cnt);
    end
  endtask

  task automatic test_same_dest();
    set_bundle(T_ADD, T_ADD, 5'd7, 5'd7, 32'd1, 32'd2, 32'd0, 32'd0, 32'h104);
    step();
    exp_cnt = exp_cnt + 32'd2;
    checks++;
    if ({u_we, l_we, l_waddr, l_wdata} !== {1'b0, 1'b1, 5'd7, 32'd2}) begin
      errors++;
      $display("FAIL same_dest: got u_we=%b l_we=%b l_addr=%0d l_data=%h expected 0/1/7/00000002",
               u_we, l_we, l_waddr, l_wdata);
    end
    set_bundle(T_ADD, T_ADD, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 32'd0, 32'h108);
    step();
    exp_cnt = exp_cnt + 32'd2;
    checks++;
    if ({u_we, l_we} !== 2'b00) begin
      errors++;
      $display("FAIL rt_zero: got we=%b%b expected 00", u_we, l_we);
    end
    checks++;
    if (retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL same_dest_count: got %h expected %h", retire_count, exp_cnt);
    end
  endtask

  task automatic test_interlock();
    set_bundle(T_ADD, T_LOAD, 5'd10, 5'd11, 32'hA, 32'hEE, 32'hCC, 32'hB, 32'h200);
    interlock = 1'b1;
    step();
    checks++;
    if ({u_we, l_we} !== 2'b00 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL interlock_hold: got we=%b%b count=%h expected 00/%h", u_we, l_we, retire_count, exp_cnt);
    end
    checks++;
    if (retired_pc !== 32'h108 || u_waddr !== 5'd0) begin
      errors++;
      $display("FAIL interlock_regs: got pc=%h u_addr=%0d expected 00000108/0", retired_pc, u_waddr);
    end
    interlock = 1'b0;
    step();
    exp_cnt = exp_cnt + 32'd2;
    checks++;
    if ({u_we, u_waddr, u_wdata, l_we, l_waddr, l_wdata} !== {1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB}) begin
      errors++;
      $display("FAIL interlock_release: got u=%b/%0d/%h l=%b/%0d/%h expected 1/10/a 1/11/b",
               u_we, u_waddr, u_wdata, l_we, l_waddr, l_wdata);
    end
    checks++;
    if (retire_count !== exp_cnt || retired_pc !== 32'h200) begin
      errors++;
      $display("FAIL interlock_count: got %h pc=%h expected %h/00000200", retire_count, retired_pc, exp_cnt);
    end
    set_bundle(T_NOP, T_NOP, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h204);
    step();
    checks++;
    if ({u_we, l_we} !== 2'b00 || retire_count !== exp_cnt) begin
      errors++;
      $display("FAIL write_once: got we=%b%b count=%h expected 00/%h", u_we, l_we, retire_count, exp_cnt);
    end
  endtask

  task automatic test_hazard();
    logic exp_a [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic il_b  [8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_b [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    id_rs      = {5'd0, 5'd0, 5'd3, 5'd0};
    u_ld_issue = 1'b1;
    u_ld_rt    = 5'd3;
    #1;
    checks++;
    if (load_hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_issue: got %b expected 1", load_hazard);
    end
    step();
    u_ld_issue = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (load_hazard !== exp_a[i]) begin
        errors++;
        $display("FAIL hazard_chain[%0d]: got %b expected %b", i, load_hazard, exp_a[i]);
      end
      step();
    end
    u_ld_issue = 1'b1;
    step();
    u_ld_issue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (load_hazard !== exp_b[i]) begin
        errors++;
        $display("FAIL hazard_interlock[%0d]: got %b expected %b", i, load_hazard, exp_b[i]);
      end
      interlock = il_b[i];
      step();
    end
    interlock  = 1'b0;
    u_ld_issue = 1'b1;
    u_ld_rt    = 5'd0;
    id_rs      = 20'd0;
    #1;
    checks++;
    if (load_hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_rs_zero: got %b expected 0", load_hazard);
    end
    u_ld_issue = 1'b0;
    l_ld_issue = 1'b1;
    l_ld_rt    = 5'd9;
    id_rs      = {5'd9, 5'd0, 5'd0, 5'd0};
    step();
    l_ld_issue = 1'b0;
    checks++;
    if (load_hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_lower: got %b expected 1", load_hazard);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (load_hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_lower_clear: got %b expected 0", load_hazard);
    end
    id_rs = 20'd0;
  endtask

  task automatic test_wrap();
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    set_bundle(T_NOP, T_ADD, 5'd0, 5'd12, 32'd0, 32'h77, 32'd0, 32'd0, 32'h300);
    step();
    checks++;
    if (retire_count !== 32'd0 || {u_we, l_we} !== 2'b01 || l_wdata !== 32'h77) begin
      errors++;
      $display("FAIL wrap: got count=%h we=%b%b l_data=%h expected 00000000/01/00000077",
               retire_count, u_we, l_we, l_wdata);
    end
    step();
    checks++;
    if (retire_count !== 32'd1) begin
      errors++;
      $display("FAIL nop_alu_inc: got %h expected 00000001", retire_count);
    end
  endtask

  task automatic test_reset_mid();
    set_bundle(T_LOAD, T_ADD, 5'd4, 5'd8, 32'd0, 32'h5, 32'h1234, 32'd0, 32'h400);
    u_ld_issue = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      u_ld_rt = 5'(i);
      step();
    end
    u_ld_issue = 1'b0;
    id_rs      = {5'd0, 5'd0, 5'd0, 5'd1};
    #1;
    checks++;
    if (load_hazard !== 1'b1 || u_we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got hazard=%b u_we=%b expected 1/1", load_hazard, u_we);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({u_we, l_we, u_waddr, l_waddr, u_wdata, l_wdata, retired_pc, retire_count} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got we=%b/%b count=%h pc=%h expected all zero",
               u_we, l_we, retire_count, retired_pc);
    end
    checks++;
    if (load_hazard !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_hazard: got %b expected 0", load_hazard);
    end
    step();
    rst = 1'b0;
    set_bundle(T_NOP, T_NOP, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h500);
    step();
    checks++;
    if (retire_count !== 32'd0 || {u_we, l_we} !== 2'b00 || load_hazard !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got count=%h we=%b%b hazard=%b expected 0/00/0",
               retire_count, u_we, l_we, load_hazard);
    end
  endtask

  initial begin
    test_reset();
    test_load_alu();
    test_same_dest();
    test_interlock();
    test_hazard();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
